// File: rtl/arm_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : arm_control_unit_if
//  Purpose  : Bundles the instruction/flag inputs and every datapath control
//             output of the ARM-subset control unit.
//  Ports    : Instr (32), Z/N/C/V ALU flags        -> control unit
//             PCSrc, RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl,
//             MemWrite, MemtoReg, pc_en, flags, halted, illegal
//                                                  <- control unit
//  Modports : master - datapath side (drives Instr and ALU flags)
//             slave  - control unit side
//  Revision : 1.0  initial release
// ============================================================================
interface arm_control_unit_if;
    logic [31:0] Instr;
    logic        Z;
    logic        N;
    logic        C;
    logic        V;
    logic        PCSrc;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic        ALUSrc;
    logic [1:0]  ALUControl;
    logic        MemWrite;
    logic        MemtoReg;
    logic        pc_en;
    logic [3:0]  flags;
    logic        halted;
    logic        illegal;

    modport master (
        output Instr, Z, N, C, V,
        input  PCSrc, RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl,
               MemWrite, MemtoReg, pc_en, flags, halted, illegal
    );

    modport slave (
        input  Instr, Z, N, C, V,
        output PCSrc, RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl,
               MemWrite, MemtoReg, pc_en, flags, halted, illegal
    );
endinterface
`default_nettype wire

// File: rtl/arm_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : arm_control_unit
//  Purpose  : Control unit for the single-cycle ARM-subset datapath. Decodes
//             the current instruction, evaluates the condition field against
//             the NZCV register, owns that register, and runs a BOOT/RUN/HALT
//             sequencer that hides the instruction ROM read latency and stops
//             the core on halt (cond=1111) or unsupported encodings.
//  Ports    : clock  - single rising-edge clock
//             reset  - synchronous, active-high
//             bus    - arm_control_unit_if.slave (instruction, ALU flags in;
//                      datapath controls, flags, halted, illegal out)
//  Params   : BOOT_CYCLES (1..15) cycles spent in BOOT after reset
//             HALT_ON_NV  1: cond=1111 halts; 0: cond=1111 never executes
//  Revision : 1.0  initial release
// ============================================================================
module arm_control_unit #(
    parameter int BOOT_CYCLES = 1,
    parameter bit HALT_ON_NV  = 1'b1
) (
    input  wire logic         clock,
    input  wire logic         reset,
    arm_control_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [3:0] c_BOOT_LAST = 4'(BOOT_CYCLES - 1);

    localparam logic [3:0] c_CMD_AND = 4'b0000;
    localparam logic [3:0] c_CMD_SUB = 4'b0010;
    localparam logic [3:0] c_CMD_ADD = 4'b0100;
    localparam logic [3:0] c_CMD_CMP = 4'b1010;
    localparam logic [3:0] c_CMD_ORR = 4'b1100;

    localparam logic [1:0] c_ALU_ADD = 2'b00;
    localparam logic [1:0] c_ALU_SUB = 2'b01;
    localparam logic [1:0] c_ALU_AND = 2'b10;
    localparam logic [1:0] c_ALU_ORR = 2'b11;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_boot_cnt;
    logic [3:0] r_flags;        // {N,Z,C,V}
    logic       r_illegal;

    // Instruction fields
    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [3:0] w_cmd;
    logic       w_sbit;
    logic [3:0] w_rd;

    // Raw decode (before condition/halt gating)
    logic [1:0] w_regsrc;
    logic [1:0] w_immsrc;
    logic       w_alusrc;
    logic [1:0] w_aluctl;
    logic       w_memtoreg;
    logic       w_regw;
    logic       w_memw;
    logic       w_branch;
    logic       w_nowrite;
    logic       w_arith;
    logic       w_bad_enc;
    logic [1:0] w_flagw;
    logic       w_pcs;
    logic       w_cond_ex;
    logic       w_halt_req;
    logic       w_boot_done;

    // Gated outputs and register enables
    logic       w_pcsrc_o;
    logic       w_regwrite_o;
    logic       w_memwrite_o;
    logic [1:0] w_regsrc_o;
    logic [1:0] w_immsrc_o;
    logic       w_alusrc_o;
    logic [1:0] w_aluctl_o;
    logic       w_memtoreg_o;
    logic       w_pc_en_o;
    logic       w_nz_en;
    logic       w_cv_en;

    // Offset/immediate and Rn fields are consumed by the datapath only.
    logic       w_unused_fields;
    assign w_unused_fields = ^{bus.Instr[19:16], bus.Instr[11:0]};

    assign w_cond      = bus.Instr[31:28];
    assign w_op        = bus.Instr[27:26];
    assign w_cmd       = bus.Instr[24:21];
    assign w_sbit      = bus.Instr[20];
    assign w_rd        = bus.Instr[15:12];
    assign w_boot_done = (r_boot_cnt == c_BOOT_LAST);

    // ------------------------------------------------------------------
    // Main + ALU decode
    // ------------------------------------------------------------------
    always_comb begin
        w_regsrc   = 2'b00;
        w_immsrc   = 2'b00;
        w_alusrc   = 1'b0;
        w_aluctl   = c_ALU_ADD;
        w_memtoreg = 1'b0;
        w_regw     = 1'b0;
        w_memw     = 1'b0;
        w_branch   = 1'b0;
        w_nowrite  = 1'b0;
        w_arith    = 1'b0;
        w_bad_enc  = 1'b0;
        case (w_op)
            2'b00: begin
                w_alusrc = bus.Instr[25];
                w_regw   = 1'b1;
                case (w_cmd)
                    c_CMD_ADD: begin w_aluctl = c_ALU_ADD; w_arith = 1'b1; end
                    c_CMD_SUB: begin w_aluctl = c_ALU_SUB; w_arith = 1'b1; end
                    c_CMD_AND: w_aluctl = c_ALU_AND;
                    c_CMD_ORR: w_aluctl = c_ALU_ORR;
                    c_CMD_CMP: begin
                        w_aluctl  = c_ALU_SUB;
                        w_arith   = 1'b1;
                        w_nowrite = 1'b1;
                    end
                    default:   w_bad_enc = 1'b1;
                endcase
            end
            2'b01: begin
                // Instr[20] is the L bit: LDR reads Rd-from-memory, STR
                // needs Rd on the second read port for the store data.
                w_immsrc   = 2'b01;
                w_alusrc   = 1'b1;
                w_memtoreg = bus.Instr[20];
                w_regw     = bus.Instr[20];
                w_memw     = ~bus.Instr[20];
                w_regsrc   = bus.Instr[20] ? 2'b00 : 2'b10;
            end
            2'b10: begin
                w_regsrc = 2'b01;
                w_immsrc = 2'b10;
                w_alusrc = 1'b1;
                w_branch = 1'b1;
            end
            default: w_bad_enc = 1'b1;
        endcase
    end

    assign w_flagw    = (w_op == 2'b00) ? {w_sbit, w_sbit & w_arith} : 2'b00;
    assign w_pcs      = w_branch | (w_regw & (w_rd == 4'hF));
    assign w_halt_req = w_bad_enc | (HALT_ON_NV && (w_cond == 4'hF));

    // ------------------------------------------------------------------
    // Condition check on the registered (pre-update) flags
    // ------------------------------------------------------------------
    always_comb begin
        w_cond_ex = 1'b0;
        case (w_cond)
            4'h0: w_cond_ex = r_flags[2];
            4'h1: w_cond_ex = ~r_flags[2];
            4'h2: w_cond_ex = r_flags[1];
            4'h3: w_cond_ex = ~r_flags[1];
            4'h4: w_cond_ex = r_flags[3];
            4'h5: w_cond_ex = ~r_flags[3];
            4'h6: w_cond_ex = r_flags[0];
            4'h7: w_cond_ex = ~r_flags[0];
            4'h8: w_cond_ex = r_flags[1] & ~r_flags[2];
            4'h9: w_cond_ex = ~r_flags[1] | r_flags[2];
            4'hA: w_cond_ex = (r_flags[3] == r_flags[0]);
            4'hB: w_cond_ex = (r_flags[3] != r_flags[0]);
            4'hC: w_cond_ex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            4'hD: w_cond_ex = r_flags[2] | (r_flags[3] != r_flags[0]);
            4'hE: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;   // NV never executes
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer next-state and output gating
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_pcsrc_o    = 1'b0;
        w_regwrite_o = 1'b0;
        w_memwrite_o = 1'b0;
        w_regsrc_o   = 2'b00;
        w_immsrc_o   = 2'b00;
        w_alusrc_o   = 1'b0;
        w_aluctl_o   = 2'b00;
        w_memtoreg_o = 1'b0;
        w_pc_en_o    = 1'b0;
        w_nz_en      = 1'b0;
        w_cv_en      = 1'b0;
        case (r_state)
            ST_BOOT: begin
                // PC advances in the last BOOT cycle so the ROM presents
                // word 0 in the first RUN cycle.
                w_pc_en_o = w_boot_done;
                if (w_boot_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_pc_en_o    = 1'b1;
                w_regsrc_o   = w_regsrc;
                w_immsrc_o   = w_immsrc;
                w_alusrc_o   = w_alusrc;
                w_aluctl_o   = w_aluctl;
                w_memtoreg_o = w_memtoreg;
                if (w_halt_req) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_pcsrc_o    = w_pcs & w_cond_ex;
                    w_regwrite_o = w_regw & w_cond_ex & ~w_nowrite;
                    w_memwrite_o = w_memw & w_cond_ex;
                    w_nz_en      = w_flagw[1] & w_cond_ex;
                    w_cv_en      = w_flagw[0] & w_cond_ex;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: w_state_nxt = ST_BOOT;
        endcase
        if (reset) begin
            w_pcsrc_o    = 1'b0;
            w_regwrite_o = 1'b0;
            w_memwrite_o = 1'b0;
            w_regsrc_o   = 2'b00;
            w_immsrc_o   = 2'b00;
            w_alusrc_o   = 1'b0;
            w_aluctl_o   = 2'b00;
            w_memtoreg_o = 1'b0;
            w_pc_en_o    = 1'b0;
            w_nz_en      = 1'b0;
            w_cv_en      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State, boot counter, NZCV and sticky illegal flag
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_BOOT;
            r_boot_cnt <= 4'd0;
            r_flags    <= 4'b0000;
            r_illegal  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_BOOT) begin
                r_boot_cnt <= r_boot_cnt + 4'd1;
            end
            if (w_nz_en) begin
                r_flags[3] <= bus.N;
                r_flags[2] <= bus.Z;
            end
            if (w_cv_en) begin
                r_flags[1] <= bus.C;
                r_flags[0] <= bus.V;
            end
            if ((r_state == ST_RUN) && w_bad_enc) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign bus.PCSrc      = w_pcsrc_o;
    assign bus.RegSrc     = w_regsrc_o;
    assign bus.RegWrite   = w_regwrite_o;
    assign bus.ImmSrc     = w_immsrc_o;
    assign bus.ALUSrc     = w_alusrc_o;
    assign bus.ALUControl = w_aluctl_o;
    assign bus.MemWrite   = w_memwrite_o;
    assign bus.MemtoReg   = w_memtoreg_o;
    assign bus.pc_en      = w_pc_en_o;
    assign bus.flags      = reset ? 4'b0000 : r_flags;
    assign bus.halted     = ~reset & (r_state == ST_HALT);
    assign bus.illegal    = ~reset & r_illegal;

endmodule
`default_nettype wire
